// File: rtl/percept_ctrl.sv
// Host-side sequencer for one percept cell: serializes a weight/input pair,
// strobes multiply-accumulate, and optionally deserializes the accumulator.
module percept_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ACC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_weight,
  input  logic [WIDTH-1:0] cmd_in,
  input  logic             cmd_read,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             shift_in,
  output logic             data_in,
  output logic             mul_and_acc,
  output logic             shift_out,
  input  logic             data_out
);

  localparam int CNT_MAX = (WIDTH > ACC_CYCLES) ? WIDTH : ACC_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    MAC,
    READ,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] res_d;

  logic cmd_ready_d, res_valid_d, busy_d;
  logic shift_in_d, data_in_d, mul_and_acc_d, shift_out_d;

  // Next state and datapath. One shared down-counter paces every timed state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    x_d     = x_q;
    rd_d    = rd_q;
    cap_d   = cap_q;
    res_d   = res_data;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = LOAD_W;
          cnt_d   = LOAD_LAST;
          w_d     = cmd_weight;
          x_d     = cmd_in;
          rd_d    = cmd_read;
        end
      end
      LOAD_W: begin
        if (cnt_q == '0) begin
          state_d = LOAD_X;
          cnt_d   = LOAD_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD_X: begin
        if (cnt_q == '0) begin
          state_d = MAC;
          cnt_d   = ACC_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MAC: begin
        if (cnt_q == '0) begin
          state_d = rd_q ? READ : IDLE;
          cnt_d   = LOAD_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READ: begin
        // First sample lands in the MSB after WIDTH left shifts.
        cap_d = {cap_q[WIDTH-2:0], data_out};
        if (cnt_q == '0) begin
          state_d = RESP;
          res_d   = cap_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered
  // and line up with the state they describe.
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    shift_in_d    = (state_d == LOAD_W) || (state_d == LOAD_X);
    mul_and_acc_d = (state_d == MAC);
    shift_out_d   = (state_d == READ);
    res_valid_d   = (state_d == RESP);
    data_in_d     = 1'b0;
    if (state_d == LOAD_W)      data_in_d = w_d[cnt_d];
    else if (state_d == LOAD_X) data_in_d = x_d[cnt_d];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      rd_q        <= 1'b0;
      cap_q       <= '0;
      res_data    <= '0;
      cmd_ready   <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      shift_in    <= 1'b0;
      data_in     <= 1'b0;
      mul_and_acc <= 1'b0;
      shift_out   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      x_q         <= x_d;
      rd_q        <= rd_d;
      cap_q       <= cap_d;
      res_data    <= res_d;
      cmd_ready   <= cmd_ready_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      shift_in    <= shift_in_d;
      data_in     <= data_in_d;
      mul_and_acc <= mul_and_acc_d;
      shift_out   <= shift_out_d;
    end
  end

endmodule

// File: tb/tb_percept_ctrl.sv
// Directed bench for percept_ctrl: a 32-bit/1-cycle instance and an
// 8-bit/3-cycle instance share one clock, reset and stimulus driver.
module tb_percept_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_weight;
  logic [31:0] cmd_in;
  logic        cmd_read;
  logic        res_ready;
  logic        data_out;
  logic        sel_b;

  logic        a_cmd_ready, a_res_valid, a_busy, a_shift_in, a_data_in, a_mac, a_shift_out;
  logic [31:0] a_res_data;
  logic        b_cmd_ready, b_res_valid, b_busy, b_shift_in, b_data_in, b_mac, b_shift_out;
  logic [7:0]  b_res_data;

  logic        o_cmd_ready, o_res_valid, o_busy, o_shift_in, o_data_in, o_mac, o_shift_out;
  logic [31:0] o_res_data;

  always #5 clk = ~clk;

  percept_ctrl #(.WIDTH(32), .ACC_CYCLES(1)) u_a (
    .clk(clk), .Rst(rst),
    .cmd_valid(cmd_valid & ~sel_b), .cmd_ready(a_cmd_ready),
    .cmd_weight(cmd_weight), .cmd_in(cmd_in), .cmd_read(cmd_read),
    .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data),
    .busy(a_busy), .shift_in(a_shift_in), .data_in(a_data_in),
    .mul_and_acc(a_mac), .shift_out(a_shift_out), .data_out(data_out)
  );

  percept_ctrl #(.WIDTH(8), .ACC_CYCLES(3)) u_b (
    .clk(clk), .Rst(rst),
    .cmd_valid(cmd_valid & sel_b), .cmd_ready(b_cmd_ready),
    .cmd_weight(cmd_weight[7:0]), .cmd_in(cmd_in[7:0]), .cmd_read(cmd_read),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data),
    .busy(b_busy), .shift_in(b_shift_in), .data_in(b_data_in),
    .mul_and_acc(b_mac), .shift_out(b_shift_out), .data_out(data_out)
  );

  assign o_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
  assign o_res_valid = sel_b ? b_res_valid : a_res_valid;
  assign o_busy      = sel_b ? b_busy      : a_busy;
  assign o_shift_in  = sel_b ? b_shift_in  : a_shift_in;
  assign o_data_in   = sel_b ? b_data_in   : a_data_in;
  assign o_mac       = sel_b ? b_mac       : a_mac;
  assign o_shift_out = sel_b ? b_shift_out : a_shift_out;
  assign o_res_data  = sel_b ? {24'h0, b_res_data} : a_res_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last run_cmd, in cycles counted from the accept edge.
  logic [63:0] stream;
  logic [31:0] res;
  int n_in, n_mac, n_out, mac_first, rv_first, rv_cycles, done_k;
  int onehot_bad, din_bad, stable_bad, ready_bad;

  task automatic run_cmd(input logic [31:0] wt, input logic [31:0] xin, input bit rd,
                         input logic [31:0] model, input int stall, input bit poke);
    int w;
    w = sel_b ? 8 : 32;
    stream = '0; res = '0;
    n_in = 0; n_mac = 0; n_out = 0; mac_first = -1; rv_first = -1; rv_cycles = 0;
    done_k = -1; onehot_bad = 0; din_bad = 0; stable_bad = 0; ready_bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_weight = wt; cmd_in = xin; cmd_read = rd;
    res_ready = 1'b0; data_out = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (poke && k == w + 3) begin
        cmd_valid = 1'b1; cmd_weight = 32'hFFFF_FFFF; cmd_in = 32'h5555_5555; cmd_read = 1'b1;
      end
      if (poke && k == w + 5) cmd_valid = 1'b0;
      if (int'(o_shift_in) + int'(o_mac) + int'(o_shift_out) > 1) onehot_bad++;
      if (!o_shift_in && o_data_in) din_bad++;
      if (o_shift_in) begin
        stream = {stream[62:0], o_data_in};
        n_in++;
      end
      if (o_mac) begin
        if (mac_first < 0) mac_first = k;
        n_mac++;
      end
      if (o_shift_out) begin
        data_out = model[w-1-n_out];
        n_out++;
      end else begin
        data_out = 1'b0;
      end
      if (o_res_valid) begin
        if (rv_first < 0) begin
          rv_first = k;
          res = o_res_data;
        end else if (o_res_data !== res) begin
          stable_bad++;
        end
        if (o_cmd_ready) ready_bad++;
        if (rv_cycles == stall) res_ready = 1'b1;
        rv_cycles++;
      end
      if (o_cmd_ready) begin
        done_k = k;
        break;
      end
    end
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel_b = 1'b0;
    cmd_valid = 1'b0; cmd_weight = '0; cmd_in = '0; cmd_read = 1'b0;
    res_ready = 1'b0; data_out = 1'b0;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_weight = $urandom; cmd_in = $urandom;
      cmd_read = 1'($urandom); res_ready = 1'($urandom); data_out = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0; data_out = 1'b0;
    #1;
    check("rst_a_outs", {a_cmd_ready, a_res_valid, a_busy, a_shift_in, a_data_in, a_mac, a_shift_out},
          7'b1000000);
    check("rst_a_res", a_res_data, 32'h0);
    check("rst_b_outs", {b_cmd_ready, b_res_valid, b_busy, b_shift_in, b_data_in, b_mac, b_shift_out},
          7'b1000000);
    check("rst_b_res", b_res_data, 8'h0);

    // Serialization, no read.
    run_cmd(32'h0000_07D0, 32'h0000_03E8, 1'b0, 32'h0, 0, 1'b0);
    check("ser_stream", stream, 64'h0000_07D0_0000_03E8);
    check("ser_n_in", n_in, 64);
    check("ser_n_mac", n_mac, 1);
    check("ser_mac_at", mac_first, 65);
    check("ser_idle_at", done_k, 66);
    check("ser_no_res", rv_first, -1);
    check("ser_onehot", onehot_bad, 0);
    check("ser_din_zero", din_bad, 0);

    // Readout with immediate acceptance.
    run_cmd(32'h0000_07D0, 32'h0000_03E8, 1'b1, 32'h001E_8480, 0, 1'b0);
    check("rd_res", res, 32'h001E_8480);
    check("rd_valid_at", rv_first, 98);
    check("rd_n_out", n_out, 32);
    check("rd_resp_len", rv_cycles, 1);
    check("rd_idle_at", done_k, 99);
    check("rd_onehot", onehot_bad, 0);

    // Backpressure: res_ready low for 10 res_valid cycles.
    run_cmd(32'h1234_5678, 32'h0BAD_F00D, 1'b1, 32'hC0DE_1234, 10, 1'b0);
    check("bp_res", res, 32'hC0DE_1234);
    check("bp_valid_at", rv_first, 98);
    check("bp_resp_len", rv_cycles, 11);
    check("bp_stable", stable_bad, 0);
    check("bp_ready_low", ready_bad, 0);
    check("bp_idle_at", done_k, 109);

    // cmd_valid pulsed with other data during LOAD_X is ignored.
    run_cmd(32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 32'h0, 0, 1'b1);
    check("ign_stream", stream, 64'h8000_0001_7FFF_FFFE);
    check("ign_idle_at", done_k, 66);
    check("ign_no_res", rv_first, -1);

    // Reset at cycle 40 of a command, then a fresh command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_weight = 32'hDEAD_BEEF; cmd_in = 32'hCAFE_BABE; cmd_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_busy", a_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_shift_in", a_shift_in, 1'b0);
    check("mid_outs", {a_cmd_ready, a_res_valid, a_busy, a_data_in, a_mac, a_shift_out}, 6'b100000);
    run_cmd(32'hA5A5_0F0F, 32'h0102_0304, 1'b0, 32'h0, 0, 1'b0);
    check("mid_fresh", stream, 64'hA5A5_0F0F_0102_0304);
    check("mid_fresh_idle", done_k, 66);

    // WIDTH=8, ACC_CYCLES=3 instance.
    sel_b = 1'b1;
    run_cmd(32'h0000_00A5, 32'h0000_003C, 1'b1, 32'h0000_005A, 0, 1'b0);
    check("b_stream", stream[15:0], 16'hA53C);
    check("b_n_in", n_in, 16);
    check("b_n_mac", n_mac, 3);
    check("b_mac_at", mac_first, 17);
    check("b_valid_at", rv_first, 28);
    check("b_res", res, 32'h0000_005A);
    check("b_idle_at", done_k, 29);
    check("b_onehot", onehot_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
